// File: rtl/dual_issue_queue.sv
// dual_issue_queue
// Program-ordered instruction buffer between fetch and the dual-issue control
// unit. Fetch writes up to two instructions per cycle. Each time the lane
// registers load, the queue head goes to lane A. The next-oldest entry is
// paired onto lane B only when the two instructions can safely issue together.
// Lane outputs are registered. There is no bypass from fetch to the lanes.
module dual_issue_queue #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid0,
   input  logic        in_valid1,
   input  logic [31:0] in_instr0,
   input  logic [31:0] in_instr1,
   output logic        in_ready,
   input  logic        flush,
   input  logic        mode,
   input  logic        out_ready,
   output logic        out_valid_a,
   output logic        out_valid_b,
   output logic [31:0] out_instr_a,
   output logic [31:0] out_instr_b,
   output logic [6:0]  opcodeA,
   output logic [2:0]  funct3A,
   output logic [6:0]  funct7A,
   output logic [6:0]  opcodeB,
   output logic [2:0]  funct3B,
   output logic [6:0]  funct7B
);

   localparam int PW = $clog2(DEPTH);

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // A control transfer must issue alone, so that lane B never holds a wrong-path instruction.
   function automatic logic is_ctrl(input logic [6:0] op);
      return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
   endfunction

   // There is only one memory port, so two memory operations cannot pair.
   function automatic logic is_mem(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   // These formats write a destination register.
   function automatic logic writes_rd(input logic [6:0] op);
      return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LOAD) ||
             (op == OP_JALR)  || (op == OP_JAL)   || (op == OP_LUI)  ||
             (op == OP_AUIPC);
   endfunction

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;

   logic          push0;
   logic          push1;
   logic [PW:0]   n_push;
   logic [PW:0]   n_pop;
   logic [31:0]   h0;
   logic [31:0]   h1;
   logic          load;
   logic          issue_a;
   logic          issue_b;
   logic          raw;
   logic [4:0]    h0_rd;

   // in_ready depends only on the registered count, so fetch sees no combinational loop.
   assign in_ready = (count <= (PW+1)'(DEPTH - 2));

   assign push0  = in_ready & in_valid0;
   assign push1  = push0 & in_valid1;
   assign n_push = (PW+1)'(push0) + (PW+1)'(push1);

   assign h0 = mem[rd_ptr];
   assign h1 = mem[rd_ptr + PW'(1)];

   assign load = !out_valid_a | out_ready;

   // The rs fields of H1 are compared whatever its format. A false hazard only costs a lost pairing.
   assign h0_rd = h0[11:7];
   assign raw   = writes_rd(h0[6:0]) && (h0_rd != 5'd0) &&
                  ((h0_rd == h1[19:15]) || (h0_rd == h1[24:20]));

   assign issue_a = (count != '0);
   assign issue_b = (count >= (PW+1)'(2)) && !mode && !is_ctrl(h0[6:0]) &&
                    !(is_mem(h0[6:0]) && is_mem(h1[6:0])) && !raw;

   assign n_pop = load ? ((PW+1)'(issue_a) + (PW+1)'(issue_b)) : '0;

   // ---- queue storage: data only, no reset ----
   // Write the incoming instructions at the tail. A flush discards same-cycle pushes.
   always_ff @(posedge clk) begin
      if (push0 && !flush) mem[wr_ptr] <= in_instr0;
      if (push1 && !flush) mem[wr_ptr + PW'(1)] <= in_instr1;
   end

   // Pointers, occupancy and lane valids. Flush overrides push, pop and load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         out_valid_a <= 1'b0;
         out_valid_b <= 1'b0;
      end else if (flush) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         out_valid_a <= 1'b0;
         out_valid_b <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + n_push[PW-1:0];
         rd_ptr <= rd_ptr + n_pop[PW-1:0];
         count  <= count + n_push - n_pop;
         if (load) begin
            out_valid_a <= issue_a;
            out_valid_b <= issue_b;
         end
      end
   end

   // ---- lane output registers ----
   // Lane instruction registers load only when their lane becomes valid. Otherwise they hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_instr_a <= '0;
         out_instr_b <= '0;
      end else if (load && !flush) begin
         if (issue_a) out_instr_a <= h0;
         if (issue_b) out_instr_b <= h1;
      end
   end

   assign opcodeA = out_instr_a[6:0];
   assign funct3A = out_instr_a[14:12];
   assign funct7A = out_instr_a[31:25];
   assign opcodeB = out_instr_b[6:0];
   assign funct3B = out_instr_b[14:12];
   assign funct7B = out_instr_b[31:25];

endmodule

// File: tb/tb_dual_issue_queue.sv
// tb_dual_issue_queue
// Directed vector table, hand-written backpressure/flush/reset sequences and a
// randomized run checked against a queue-based reference model.
module tb_dual_issue_queue;

   localparam int DEPTH = 8;

   localparam logic [31:0] ADD1 = 32'h003100B3;
   localparam logic [31:0] ADD2 = 32'h00628233;
   localparam logic [31:0] SUB  = 32'h402083B3;
   localparam logic [31:0] BEQ  = 32'h00208063;
   localparam logic [31:0] XI   = 32'h00A48433;
   localparam logic [31:0] YI   = 32'h00D60633;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
   logic [31:0] in_instr0 = '0, in_instr1 = '0;
   logic        in_ready;
   logic        flush = 1'b0, mode = 1'b0, out_ready = 1'b1;
   logic        out_valid_a, out_valid_b;
   logic [31:0] out_instr_a, out_instr_b;
   logic [6:0]  opcodeA, funct7A, opcodeB, funct7B;
   logic [2:0]  funct3A, funct3B;

   int n_vec = 0;
   int n_err = 0;

   dual_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid0(in_valid0), .in_valid1(in_valid1),
      .in_instr0(in_instr0), .in_instr1(in_instr1),
      .in_ready(in_ready), .flush(flush), .mode(mode), .out_ready(out_ready),
      .out_valid_a(out_valid_a), .out_valid_b(out_valid_b),
      .out_instr_a(out_instr_a), .out_instr_b(out_instr_b),
      .opcodeA(opcodeA), .funct3A(funct3A), .funct7A(funct7A),
      .opcodeB(opcodeB), .funct3B(funct3B), .funct7B(funct7B)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] mq[$];
   logic        mva = 1'b0, mvb = 1'b0;
   logic [31:0] mia = '0, mib = '0;

   function automatic bit can_pair(input logic [31:0] a, input logic [31:0] b, input logic md);
      logic [4:0] rd;
      rd = a[11:7];
      if (md) return 1'b0;
      if (a[6:0] inside {7'h63, 7'h6F, 7'h67}) return 1'b0;
      if ((a[6:0] inside {7'h03, 7'h23}) && (b[6:0] inside {7'h03, 7'h23})) return 1'b0;
      if ((a[6:0] inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h6F, 7'h37, 7'h17}) &&
          rd != 5'd0 && (rd == b[19:15] || rd == b[24:20])) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit model_rdy();
      return (DEPTH - int'(mq.size())) >= 2;
   endfunction

   task automatic model_reset();
      mq.delete();
      mva = 1'b0; mvb = 1'b0; mia = '0; mib = '0;
   endtask

   task automatic model_step();
      bit rdy;
      rdy = model_rdy();
      if (flush) begin
         mq.delete();
         mva = 1'b0; mvb = 1'b0;
         return;
      end
      if (!mva || out_ready) begin
         if (mq.size() == 0) begin
            mva = 1'b0; mvb = 1'b0;
         end else begin
            mva = 1'b1;
            mia = mq.pop_front();
            if (mq.size() > 0 && can_pair(mia, mq[0], mode)) begin
               mvb = 1'b1;
               mib = mq.pop_front();
            end else begin
               mvb = 1'b0;
            end
         end
      end
      if (rdy && in_valid0) begin
         mq.push_back(in_instr0);
         if (in_valid1) mq.push_back(in_instr1);
      end
   endtask

   // ---------------- checks ----------------
   task automatic check_lanes(input string name, input logic eva, input logic evb,
                              input logic [31:0] eia, input logic [31:0] eib, input logic erdy);
      bit ok;
      ok = 1'b1;
      n_vec++;
      if (out_valid_a !== eva || out_valid_b !== evb || in_ready !== erdy) ok = 1'b0;
      if (eva && (out_instr_a !== eia || opcodeA !== eia[6:0] ||
                  funct3A !== eia[14:12] || funct7A !== eia[31:25])) ok = 1'b0;
      if (evb && (out_instr_b !== eib || opcodeB !== eib[6:0] ||
                  funct3B !== eib[14:12] || funct7B !== eib[31:25])) ok = 1'b0;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got va=%b vb=%b a=%h b=%h rdy=%b, want va=%b vb=%b a=%h b=%h rdy=%b",
                  name, out_valid_a, out_valid_b, out_instr_a, out_instr_b, in_ready,
                  eva, evb, eia, eib, erdy);
      end
   endtask

   task automatic check_reset(input string name);
      n_vec++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || out_instr_a !== '0 ||
          out_instr_b !== '0 || opcodeA !== '0 || funct3A !== '0 || funct7A !== '0 ||
          opcodeB !== '0 || funct3B !== '0 || funct7B !== '0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s: got va=%b vb=%b a=%h b=%h rdy=%b, want all zero with rdy=1",
                  name, out_valid_a, out_valid_b, out_instr_a, out_instr_b, in_ready);
      end
   endtask

   task automatic cmp(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic tick(input bit use_model, input string name);
      @(posedge clk);
      model_step();
      #1;
      if (use_model) check_lanes(name, mva, mvb, mia, mib, model_rdy());
   endtask

   function automatic logic [31:0] mk_add(input logic [4:0] rd);
      return {7'b0, 5'd0, 5'd0, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [10];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
      return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 9)]};
   endfunction

   typedef struct {
      logic        iv0, iv1;
      logic [31:0] i0, i1;
      logic        md;
      logic        eva, evb;
      logic [31:0] eia, eib;
      logic        erdy;
   } vec_t;

   vec_t tbl [20];

   initial begin
      logic [31:0] pushed[$];
      logic [31:0] got[$];
      logic [31:0] zi;
      int          bad;

      // directed table: inputs on one edge, lane state expected after that edge
      tbl[0]  = '{1'b1, 1'b1, ADD1, ADD2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
      tbl[1]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, ADD1, ADD2, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, ADD1, SUB, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, ADD1, 32'h0, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, SUB, 32'h0, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, BEQ, ADD2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, BEQ, 32'h0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, ADD2, 32'h0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
      tbl[11] = '{1'b1, 1'b1, ADD1, ADD2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
      tbl[12] = '{1'b1, 1'b1, XI, YI, 1'b1, 1'b1, 1'b0, ADD1, 32'h0, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, ADD2, 32'h0, 1'b1};
      tbl[14] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, XI, 32'h0, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, YI, 32'h0, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
      tbl[17] = '{1'b1, 1'b1, ADD1, ADD2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
      tbl[18] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, ADD1, ADD2, 1'b1};
      tbl[19] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};

      // reset
      #1 rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_reset("reset");
      rst_n = 1'b1;

      // directed vectors
      for (int i = 0; i < 20; i++) begin
         in_valid0 = tbl[i].iv0; in_valid1 = tbl[i].iv1;
         in_instr0 = tbl[i].i0;  in_instr1 = tbl[i].i1;
         mode = tbl[i].md; out_ready = 1'b1; flush = 1'b0;
         tick(1'b0, "");
         check_lanes($sformatf("vec%0d", i), tbl[i].eva, tbl[i].evb, tbl[i].eia, tbl[i].eib, tbl[i].erdy);
      end
      in_valid0 = 1'b0; in_valid1 = 1'b0; mode = 1'b0;

      // backpressure: fill until in_ready drops, then drain and check order
      out_ready = 1'b0;
      for (int c = 0; c < 20 && in_ready; c++) begin
         in_valid0 = 1'b1; in_valid1 = 1'b1;
         in_instr0 = mk_add(5'(2 * c + 1)); in_instr1 = mk_add(5'(2 * c + 2));
         pushed.push_back(in_instr0); pushed.push_back(in_instr1);
         tick(1'b1, "bp_fill");
      end
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      cmp("bp_pushed", pushed.size(), DEPTH + 2);
      cmp("bp_in_ready", in_ready, 0);
      tick(1'b1, "bp_hold");
      tick(1'b1, "bp_hold");
      out_ready = 1'b1;
      for (int c = 0; c < 40 && got.size() < pushed.size(); c++) begin
         if (out_valid_a) got.push_back(out_instr_a);
         if (out_valid_b) got.push_back(out_instr_b);
         tick(1'b1, "bp_drain");
      end
      cmp("bp_count", got.size(), pushed.size());
      bad = -1;
      for (int i = 0; i < got.size() && i < pushed.size(); i++)
         if (bad < 0 && got[i] !== pushed[i]) bad = i;
      cmp("bp_order_first_bad", bad, -1);
      tick(1'b1, "bp_idle");

      // flush with six queued and lanes valid, same-cycle push discarded
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid0 = 1'b1; in_valid1 = 1'b1;
         in_instr0 = mk_add(5'(c + 10)); in_instr1 = mk_add(5'(c + 20));
         tick(1'b1, "fl_fill");
      end
      cmp("fl_lanes_before", out_valid_a, 1);
      flush = 1'b1;
      tick(1'b1, "flush");
      flush = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0;
      cmp("flush_va", out_valid_a, 0);
      cmp("flush_rdy", in_ready, 1);
      out_ready = 1'b1;
      zi = mk_add(5'd31);
      in_valid0 = 1'b1; in_instr0 = zi;
      tick(1'b1, "fl_push");
      in_valid0 = 1'b0;
      tick(1'b1, "fl_issue");
      cmp("fl_issue_va", out_valid_a, 1);
      cmp("fl_issue_instr", out_instr_a, zi);
      tick(1'b1, "fl_idle");

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid0 = 1'b1; in_valid1 = 1'b1;
         in_instr0 = mk_add(5'(c + 3)); in_instr1 = mk_add(5'(c + 7));
         tick(1'b1, "rs_fill");
      end
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      @(posedge clk);
      model_step();
      #3 rst_n = 1'b0;
      #1 check_reset("rst_async");
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      in_valid0 = 1'b1; in_valid1 = 1'b1; in_instr0 = ADD1; in_instr1 = ADD2;
      tick(1'b1, "rs_push");
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      tick(1'b1, "rs_issue");
      tick(1'b1, "rs_idle");

      // randomized run against the model
      for (int c = 0; c < 1500; c++) begin
         in_valid0 = ($urandom_range(0, 3) != 0) && model_rdy();
         in_valid1 = 1'($urandom_range(0, 1));
         in_instr0 = rand_instr();
         in_instr1 = rand_instr();
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 31) == 0) mode = ~mode;
         tick(1'b1, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
